// File: rtl/imem_pkg.sv
// ---------------------------------------------------------------------------
// imem_pkg -- shared definitions for the instruction-memory loader.
//
// Contents:
//   ADDR_W_DEF   default word-address width (1024-word memory)
//   BIDX_W       width of the byte index inside a 32-bit word
//   state_t      loader FSM states (IDLE, LOAD, DONE)
//   insert_byte  places one byte into a word, MSB-first ordering
// ---------------------------------------------------------------------------
package imem_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int BIDX_W     = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Byte index 0 is the most significant byte of the word.
    function automatic logic [31:0] insert_byte(
        input logic [31:0]       word,
        input logic [7:0]        data,
        input logic [BIDX_W-1:0] idx
    );
        logic [31:0] res;
        res = word;
        case (idx)
            2'd0:    res[31:24] = data;
            2'd1:    res[23:16] = data;
            2'd2:    res[15:8]  = data;
            2'd3:    res[7:0]   = data;
            default: res = word;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// ---------------------------------------------------------------------------
// imem_loader_if -- byte-stream load channel into the instruction memory.
//
// Signals:
//   ld_start  pulse that opens a load session
//   ld_valid  a byte is present on ld_byte
//   ld_byte   program byte, most significant byte of each word first
//   ld_last   marks the final byte of the session
//   ld_ready  loader accepts the byte this cycle
//
// Modports:
//   master  the byte source (host / boot ROM streamer)
//   slave   the loader
// ---------------------------------------------------------------------------
interface imem_loader_if;

    logic       ld_start;
    logic       ld_valid;
    logic [7:0] ld_byte;
    logic       ld_last;
    logic       ld_ready;

    modport master (
        output ld_start,
        output ld_valid,
        output ld_byte,
        output ld_last,
        input  ld_ready
    );

    modport slave (
        input  ld_start,
        input  ld_valid,
        input  ld_byte,
        input  ld_last,
        output ld_ready
    );

endinterface

// File: rtl/word_assembler.sv
// ---------------------------------------------------------------------------
// word_assembler -- packs accepted bytes into 32-bit words, MSB first.
//
// Ports:
//   clk       clock, rising edge
//   reset     synchronous active-high reset, drops any partial word
//   clear     start of a new session, drops any partial word
//   accept    a byte is transferred this cycle
//   byte_in   the byte being transferred
//   last      the byte is the final one of the session
//   wr_en     combinational: the current edge completes a word
//   wr_word   combinational: the completed word (zero-filled if partial)
//
// The assembly register keeps the not-yet-filled low bytes at zero, so a
// partial word closed by 'last' is already zero-filled without extra logic.
// ---------------------------------------------------------------------------
module word_assembler
    import imem_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        accept,
    input  logic [7:0]  byte_in,
    input  logic        last,
    output logic        wr_en,
    output logic [31:0] wr_word
);

    logic [BIDX_W-1:0] idx_r;
    logic [31:0]       asm_r;

    // Word completion: fourth byte, or any byte flagged as last.
    always_comb begin
        wr_word = insert_byte(asm_r, byte_in, idx_r);
        wr_en   = 1'b0;
        if (accept && ((idx_r == 2'd3) || last)) begin
            wr_en = 1'b1;
        end else begin
            wr_en = 1'b0;
        end
    end

    // Assembly register and byte index; both return to zero after each word.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            idx_r <= 2'd0;
            asm_r <= 32'h0000_0000;
        end else if (accept) begin
            if (wr_en) begin
                idx_r <= 2'd0;
                asm_r <= 32'h0000_0000;
            end else begin
                idx_r <= idx_r + 2'd1;
                asm_r <= wr_word;
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader -- instruction memory with a byte-stream program loader.
//
// Ports:
//   clk       clock, all state on rising edge
//   reset     synchronous active-high reset (memory contents are kept)
//   ld        imem_loader_if.slave byte-load channel
//   IM_A      fetch byte address; bits [ADDR_W+1:2] select the word
//   Instr     fetched word, combinational read
//   busy      session in progress (CPU holds its PC)
//   done      a session has completed
//   full      the session ended because the memory filled up
//   word_cnt  words written in the current / last session
//   csum      XOR of the words written in the session
//
// Build option: define IMEM_LOADER_CSUM_EN to include the checksum register;
// otherwise csum is tied to zero.
// ---------------------------------------------------------------------------
module imem_loader
    import imem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
)(
    input  logic              clk,
    input  logic              reset,
    imem_loader_if.slave      ld,
    input  logic [31:0]       IM_A,
    output logic [31:0]       Instr,
    output logic              busy,
    output logic              done,
    output logic              full,
    output logic [ADDR_W:0]   word_cnt,
    output logic [31:0]       csum
);

    localparam int             DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR_W:0] LAST_WORD = (ADDR_W + 1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] CNT_ONE   = (ADDR_W + 1)'(1);

    state_t            state_r;
    logic              ready_r;
    logic              busy_r;
    logic              done_r;
    logic              full_r;
    logic [ADDR_W:0]   wc_r;
    logic [31:0]       mem_r [0:DEPTH-1];

    logic              accept_s;
    logic              clear_s;
    logic              wr_en_s;
    logic [31:0]       wr_word_s;
    logic              unused_addr_s;

    // ld_ready also requires ld_valid, so it stays low across input gaps.
    assign accept_s    = ld.ld_valid & ready_r;
    assign ld.ld_ready = ready_r & ld.ld_valid;
    // ld_start only opens a session outside LOAD.
    assign clear_s     = ld.ld_start & (state_r != ST_LOAD);

    assign busy     = busy_r;
    assign done     = done_r;
    assign full     = full_r;
    assign word_cnt = wc_r;

    word_assembler u_asm (
        .clk     (clk),
        .reset   (reset),
        .clear   (clear_s),
        .accept  (accept_s),
        .byte_in (ld.ld_byte),
        .last    (ld.ld_last),
        .wr_en   (wr_en_s),
        .wr_word (wr_word_s)
    );

    // Session FSM with registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            ready_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            full_r  <= 1'b0;
            wc_r    <= '0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (ld.ld_start) begin
                        state_r <= ST_LOAD;
                        ready_r <= 1'b1;
                        busy_r  <= 1'b1;
                        done_r  <= 1'b0;
                        full_r  <= 1'b0;
                        wc_r    <= '0;
                    end
                end
                ST_LOAD: begin
                    if (wr_en_s) begin
                        wc_r <= wc_r + CNT_ONE;
                        // Capacity wins over ld_last on the same byte.
                        if (wc_r == LAST_WORD) begin
                            state_r <= ST_DONE;
                            ready_r <= 1'b0;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                            full_r  <= 1'b1;
                        end else if (ld.ld_last) begin
                            state_r <= ST_DONE;
                            ready_r <= 1'b0;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                            full_r  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    ready_r <= 1'b0;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    full_r  <= 1'b0;
                    wc_r    <= '0;
                end
            endcase
        end
    end

    // Memory write port; contents survive reset, but a write never lands
    // on the reset edge.
    always_ff @(posedge clk) begin
        if (wr_en_s && !reset) begin
            mem_r[wc_r[ADDR_W-1:0]] <= wr_word_s;
        end
    end

    // Fetch port: asynchronous read, old data until the write edge.
    assign Instr = mem_r[IM_A[ADDR_W+1:2]];

    // Byte-lane and out-of-range address bits carry no meaning here.
    assign unused_addr_s = ^{IM_A[31:ADDR_W+2], IM_A[1:0]};

`ifdef IMEM_LOADER_CSUM_EN
    logic [31:0] csum_r;

    // Running XOR of every word written in the session.
    always_ff @(posedge clk) begin
        if (reset || clear_s) begin
            csum_r <= 32'h0000_0000;
        end else if (wr_en_s) begin
            csum_r <= csum_r ^ wr_word_s;
        end
    end

    assign csum = csum_r;
`else
    assign csum = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_loader -- scoreboard bench for imem_loader.
// Stimulus pushes expectations into queues; a negedge monitor pops them:
// every change of word_cnt is matched against the model's expected count,
// and status/fetch snapshots are compared as they are requested.
// ---------------------------------------------------------------------------
module tb_imem_loader;

    localparam int AW = 10;

    localparam int K_INSTR = 0;
    localparam int K_WC    = 1;
    localparam int K_DONE  = 2;
    localparam int K_FULL  = 3;
    localparam int K_BUSY  = 4;
    localparam int K_READY = 5;
    localparam int K_CSUM  = 6;

    typedef struct {
        string       name;
        int          kind;
        logic [31:0] exp;
    } chk_t;

    logic          clk = 1'b0;
    logic          reset;
    logic [31:0]   im_a;
    logic [31:0]   instr;
    logic          busy;
    logic          done;
    logic          full;
    logic [AW:0]   word_cnt;
    logic [31:0]   csum;

    imem_loader_if lif ();

    imem_loader #(.ADDR_W(AW)) dut (
        .clk      (clk),
        .reset    (reset),
        .ld       (lif.slave),
        .IM_A     (im_a),
        .Instr    (instr),
        .busy     (busy),
        .done     (done),
        .full     (full),
        .word_cnt (word_cnt),
        .csum     (csum)
    );

    always #5 clk = ~clk;

    chk_t        chk_q[$];
    int          wc_q[$];
    int          n_vec = 0;
    int          n_bad = 0;
    bit          mon_en = 1'b0;
    logic [AW:0] prev_wc = '0;

    // Model state: 0 idle, 1 load, 2 done.
    int m_state = 0;
    int m_wc    = 0;
    int m_idx   = 0;

    // Monitor: word_cnt changes and requested snapshots.
    always @(negedge clk) begin
        int          e;
        chk_t        c;
        logic [31:0] act;
        if (mon_en) begin
            if (word_cnt !== prev_wc) begin
                n_vec++;
                if (wc_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL wc_change: got %0d, no change expected", word_cnt);
                end else begin
                    e = wc_q.pop_front();
                    if (word_cnt !== (AW + 1)'(e)) begin
                        n_bad++;
                        $display("FAIL wc_change: got %0d, expected %0d", word_cnt, e);
                    end
                end
                prev_wc = word_cnt;
            end
            if (chk_q.size() > 0) begin
                c = chk_q.pop_front();
                case (c.kind)
                    K_INSTR: act = instr;
                    K_WC:    act = 32'(word_cnt);
                    K_DONE:  act = {31'd0, done};
                    K_FULL:  act = {31'd0, full};
                    K_BUSY:  act = {31'd0, busy};
                    K_READY: act = {31'd0, lif.ld_ready};
                    K_CSUM:  act = csum;
                    default: act = 32'hxxxx_xxxx;
                endcase
                n_vec++;
                if (act !== c.exp) begin
                    n_bad++;
                    $display("FAIL %s: got %h, expected %h", c.name, act, c.exp);
                end
            end
        end
    end

    task automatic check(input string name, input int kind, input logic [31:0] exp);
        chk_t c;
        c.name = name;
        c.kind = kind;
        c.exp  = exp;
        chk_q.push_back(c);
        for (int i = 0; i < 20 && chk_q.size() > 0; i++) @(posedge clk);
        #1;
        if (chk_q.size() > 0) begin
            n_bad++;
            $display("FAIL %s: monitor timeout, got no sample, expected %h", name, exp);
            chk_q.delete();
        end
    endtask

    task automatic model_accept(input bit last);
        if (m_idx == 3 || last) begin
            m_wc++;
            wc_q.push_back(m_wc);
            m_idx = 0;
            if (m_wc == (1 << AW) || last) m_state = 2;
        end else begin
            m_idx++;
        end
    endtask

    task automatic send(input logic [7:0] b, input bit last);
        int k;
        lif.ld_valid = 1'b1;
        lif.ld_byte  = b;
        lif.ld_last  = last;
        #1;
        k = 0;
        while (!lif.ld_ready && k < 10) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (!lif.ld_ready) begin
            n_vec++;
            n_bad++;
            $display("FAIL send_ready: got ld_ready=0 for byte %h, expected 1", b);
        end else begin
            @(posedge clk);
            #1;
            model_accept(last);
        end
        lif.ld_valid = 1'b0;
        lif.ld_last  = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input bit last);
        send(w[31:24], 1'b0);
        send(w[23:16], 1'b0);
        send(w[15:8],  1'b0);
        send(w[7:0],   last);
    endtask

    task automatic start();
        lif.ld_start = 1'b1;
        @(posedge clk);
        #1;
        lif.ld_start = 1'b0;
        if (m_state != 1) begin
            if (m_wc != 0) wc_q.push_back(0);
            m_wc    = 0;
            m_idx   = 0;
            m_state = 1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        if (m_wc != 0) wc_q.push_back(0);
        m_wc    = 0;
        m_idx   = 0;
        m_state = 0;
    endtask

    task automatic check_instr(input string name, input logic [31:0] addr, input logic [31:0] exp);
        im_a = addr;
        check(name, K_INSTR, exp);
    endtask

    initial begin
        logic [31:0] csum_exp;
        reset        = 1'b1;
        im_a         = 32'h0;
        lif.ld_start = 1'b0;
        lif.ld_valid = 1'b0;
        lif.ld_byte  = 8'h00;
        lif.ld_last  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset  = 1'b0;
        mon_en = 1'b1;

        // Reset state, with ld_valid high to show the loader refuses bytes.
        lif.ld_valid = 1'b1;
        check("rst_ready", K_READY, 32'd0);
        lif.ld_valid = 1'b0;
        check("rst_busy",  K_BUSY, 32'd0);
        check("rst_done",  K_DONE, 32'd0);
        check("rst_full",  K_FULL, 32'd0);
        check("rst_wc",    K_WC,   32'd0);
        check("rst_csum",  K_CSUM, 32'd0);

        // Single full word.
        start();
        check("a_busy", K_BUSY, 32'd1);
        send_word(32'h1234_5678, 1'b1);
        check("a_wc",   K_WC,   32'd1);
        check("a_done", K_DONE, 32'd1);
        check("a_busy_low", K_BUSY, 32'd0);
        check_instr("a_instr0", 32'h0, 32'h1234_5678);

        // Six bytes: one full word plus a zero-filled partial word.
        start();
        send(8'hAA, 1'b0);
        send(8'hBB, 1'b0);
        send(8'hCC, 1'b0);
        im_a         = 32'h0;
        lif.ld_valid = 1'b1;
        lif.ld_byte  = 8'hDD;
        lif.ld_last  = 1'b0;
        check("b_rdw_old", K_INSTR, 32'h1234_5678);
        model_accept(1'b0);
        lif.ld_valid = 1'b0;
        check_instr("b_instr0", 32'h0, 32'hAABB_CCDD);
        send(8'hEE, 1'b0);
        send(8'hFF, 1'b1);
        check_instr("b_instr1", 32'h4, 32'hEEFF_0000);
        check("b_wc",   K_WC,   32'd2);
        check("b_done", K_DONE, 32'd1);
        check("b_full", K_FULL, 32'd0);

        // Gap of five idle cycles mid-word with an ignored ld_start.
        start();
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        check("c_gap_ready", K_READY, 32'd0);
        check("c_gap_busy",  K_BUSY,  32'd1);
        start();
        check("c_gap_wc",    K_WC,    32'd0);
        check("c_gap_busy2", K_BUSY,  32'd1);
        send(8'h33, 1'b0);
        send(8'h44, 1'b0);
        send_word(32'h5566_7788, 1'b1);
        check_instr("c_instr0", 32'h0, 32'h1122_3344);
        check_instr("c_instr1", 32'h4, 32'h5566_7788);
        check("c_wc",   K_WC,   32'd2);
        check("c_done", K_DONE, 32'd1);

        // Checksum of complementary halves.
        start();
        send_word(32'h0000_FFFF, 1'b0);
        send_word(32'hFFFF_0000, 1'b1);
`ifdef IMEM_LOADER_CSUM_EN
        csum_exp = 32'hFFFF_FFFF;
`else
        csum_exp = 32'h0000_0000;
`endif
        check("d_csum", K_CSUM, csum_exp);
        check_instr("d_instr0", 32'h0, 32'h0000_FFFF);

        // Preload four words, then reset midway through word 3 of a new session.
        start();
        send_word(32'h0101_0101, 1'b0);
        send_word(32'h0202_0202, 1'b0);
        send_word(32'h0303_0303, 1'b0);
        send_word(32'hDEAD_BEEF, 1'b1);
        start();
        send_word(32'hA0A0_A0A0, 1'b0);
        send_word(32'hB1B1_B1B1, 1'b0);
        send_word(32'hC2C2_C2C2, 1'b0);
        send(8'h5A, 1'b0);
        send(8'h5B, 1'b0);
        do_reset();
        lif.ld_valid = 1'b1;
        check("f_ready", K_READY, 32'd0);
        lif.ld_valid = 1'b0;
        check("f_busy", K_BUSY, 32'd0);
        check("f_done", K_DONE, 32'd0);
        check("f_wc",   K_WC,   32'd0);
        check("f_csum", K_CSUM, 32'd0);
        check_instr("f_mem0", 32'h0, 32'hA0A0_A0A0);
        check_instr("f_mem1", 32'h4, 32'hB1B1_B1B1);
        check_instr("f_mem2", 32'h8, 32'hC2C2_C2C2);
        check_instr("f_mem3", 32'hC, 32'hDEAD_BEEF);

        // Fill to capacity without ld_last.
        start();
        for (int k = 0; k < 4096; k++) begin
            send(k[7:0], 1'b0);
        end
        check("g_full", K_FULL, 32'd1);
        check("g_done", K_DONE, 32'd1);
        check("g_busy", K_BUSY, 32'd0);
        check("g_wc",   K_WC,   32'd1024);
        lif.ld_valid = 1'b1;
        lif.ld_byte  = 8'h99;
        check("g_ready_after_full", K_READY, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("g_wc_after_extra", K_WC, 32'd1024);
        lif.ld_valid = 1'b0;
        check_instr("g_instr0",    32'h0000_0000, 32'h0001_0203);
        check_instr("g_instr1023", 32'hFFFF_FFFE, 32'hFCFD_FEFF);
        check_instr("g_alias1",    32'h8000_1005, 32'h0405_0607);

        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if (wc_q.size() != 0) begin
            n_bad++;
            $display("FAIL wc_pending: got %0d unseen word_cnt changes, expected 0", wc_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
